// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the two-port data-cache arbiter.
package dmem_port_arbiter_pkg;

  localparam int WORD_ADDR_W = 30;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_rr_picker.sv
// Winner selection between core and aux ports, with a streak counter that
// forces the aux port in after CORE_STREAK_MAX back-to-back core grants.
module dmem_rr_picker
  import dmem_port_arbiter_pkg::*;
#(
  parameter int CORE_STREAK_MAX = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_i,
  output logic winner_o
);

  logic [CNT_W-1:0] streak_q;
  logic [CNT_W-1:0] streak_d;

  always_comb begin
    winner_o = PORT_CORE;
    if (!req0_i || (req1_i && (streak_q == CNT_W'(CORE_STREAK_MAX))))
      winner_o = PORT_AUX;
  end

  // Streak only counts core grants that actually made the aux port wait.
  always_comb begin
    streak_d = streak_q;
    if (!req1_i) begin
      streak_d = '0;
    end else if (grant_i) begin
      if (winner_o == PORT_AUX)
        streak_d = '0;
      else if (streak_q < CNT_W'(CORE_STREAK_MAX))
        streak_d = streak_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) streak_q <= '0;
    else       streak_q <= streak_d;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-cache port between the core memory stage (port 0) and an
// auxiliary master (port 1); req/ack sequencing with busy stalls and timeout.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int CORE_STREAK_MAX = 4,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int CNT_W           = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req0_i,
  input  logic [3:0]             we0_i,
  input  logic [WORD_ADDR_W-1:0] addr0_i,
  input  logic [31:0]            wdata0_i,
  output logic [31:0]            rdata0_o,
  output logic                   busy0_o,
  input  logic                   req1_i,
  input  logic [3:0]             we1_i,
  input  logic [WORD_ADDR_W-1:0] addr1_i,
  input  logic [31:0]            wdata1_i,
  output logic [31:0]            rdata1_o,
  output logic                   busy1_o,
  output logic                   mem_req_o,
  output logic [3:0]             mem_we_o,
  output logic [WORD_ADDR_W-1:0] mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  input  logic [31:0]            mem_rdata_i,
  input  logic                   mem_ack_i,
  output logic                   err_o,
  output logic                   owner_o
);

  arb_state_e             state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic [3:0]             mem_we_q, mem_we_d;
  logic [WORD_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic [31:0]            rdata0_q, rdata0_d;
  logic [31:0]            rdata1_q, rdata1_d;
  logic                   err_q, err_d;
  logic                   owner_q, owner_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;

  logic any_req;
  logic grant;
  logic winner;

  assign any_req = req0_i | req1_i;
  assign grant   = (state_q == ST_IDLE) && any_req;

  dmem_rr_picker #(
    .CORE_STREAK_MAX(CORE_STREAK_MAX),
    .CNT_W          (CNT_W)
  ) u_picker (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req0_i  (req0_i),
    .req1_i  (req1_i),
    .grant_i (grant),
    .winner_o(winner)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    err_d       = 1'b0;
    owner_d     = owner_q;
    tmo_d       = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d     = winner;
          mem_we_d    = (winner == PORT_AUX) ? we1_i    : we0_i;
          mem_addr_d  = (winner == PORT_AUX) ? addr1_i  : addr0_i;
          mem_wdata_d = (winner == PORT_AUX) ? wdata1_i : wdata0_i;
          mem_req_d   = 1'b1;
          tmo_d       = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An ack in the final timeout cycle still completes normally.
        if (mem_ack_i) begin
          if (owner_q == PORT_AUX) rdata1_d = mem_rdata_i;
          else                     rdata0_d = mem_rdata_i;
          mem_req_d = 1'b0;
          tmo_d     = '0;
          state_d   = ST_RESP;
        end else if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          if (owner_q == PORT_AUX) rdata1_d = '0;
          else                     rdata0_d = '0;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          tmo_d     = '0;
          state_d   = ST_RESP;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      err_q       <= 1'b0;
      owner_q     <= PORT_CORE;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      err_q       <= err_d;
      owner_q     <= owner_d;
      tmo_q       <= tmo_d;
    end
  end

  assign busy0_o = req0_i && !((state_q == ST_RESP) && (owner_q == PORT_CORE));
  assign busy1_o = req1_i && !((state_q == ST_RESP) && (owner_q == PORT_AUX));

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign err_o       = err_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus random
// accesses checked against a transaction-level arbitration/timing model.
module tb_dmem_port_arbiter;

  localparam int STREAK = 4;
  localparam int TMO    = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_i, req1_i;
  logic [3:0]  we0_i, we1_i;
  logic [29:0] addr0_i, addr1_i;
  logic [31:0] wdata0_i, wdata1_i;
  logic [31:0] rdata0_o, rdata1_o;
  logic        busy0_o, busy1_o;
  logic        mem_req_o;
  logic [3:0]  mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        err_o;
  logic        owner_o;

  int checks = 0;
  int errors = 0;
  int streak_m = 0;

  dmem_port_arbiter #(
    .CORE_STREAK_MAX(STREAK),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
    .rdata0_o(rdata0_o), .busy0_o(busy0_o),
    .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
    .rdata1_o(rdata1_o), .busy1_o(busy1_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o), .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access. Called in an IDLE cycle at posedge+1; returns in the
  // following IDLE cycle at posedge+1. lat = WAIT cycle index of the ack.
  task automatic do_access(input bit r0, input bit r1,
                           input logic [3:0] w0, input logic [3:0] w1,
                           input logic [29:0] a0, input logic [29:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int lat, input logic [31:0] ack_data,
                           output logic granted);
    bit          win;
    bit          done;
    bit          timed;
    int          k;
    logic [3:0]  ew;
    logic [29:0] ea;
    logic [31:0] ed;

    req0_i = r0; req1_i = r1;
    we0_i = w0; we1_i = w1; addr0_i = a0; addr1_i = a1;
    wdata0_i = d0; wdata1_i = d1;
    mem_ack_i = 1'b0;
    #1;
    chk("idle_busy0", 32'(busy0_o), 32'(r0));
    chk("idle_busy1", 32'(busy1_o), 32'(r1));

    // Reference arbitration: core by default, aux when core absent or streak full.
    if (!r0)                         win = 1'b1;
    else if (r1 && streak_m == STREAK) win = 1'b1;
    else                             win = 1'b0;
    if (win || !r1)           streak_m = 0;
    else if (streak_m < STREAK) streak_m++;
    ew = win ? w1 : w0;
    ea = win ? a1 : a0;
    ed = win ? d1 : d0;

    @(posedge clk_i); #1;
    granted = owner_o;
    chk("grant_owner", 32'(owner_o), 32'(win));
    chk("grant_mem_req", 32'(mem_req_o), 32'd1);
    chk("grant_mem_addr", 32'(mem_addr_o), 32'(ea));
    chk("grant_mem_we", 32'(mem_we_o), 32'(ew));
    chk("grant_mem_wdata", mem_wdata_o, ed);

    k = 0; done = 1'b0; timed = 1'b0;
    while (!done) begin
      mem_ack_i   = (k == lat);
      mem_rdata_i = (k == lat) ? ack_data : $urandom;
      addr0_i = 30'($urandom); addr1_i = 30'($urandom);
      we0_i = 4'($urandom); we1_i = 4'($urandom);
      wdata0_i = $urandom; wdata1_i = $urandom;
      @(posedge clk_i); #1;
      if (k == lat)          done = 1'b1;
      else if (k == TMO - 1) begin done = 1'b1; timed = 1'b1; end
      if (!done) begin
        chk("wait_mem_req", 32'(mem_req_o), 32'd1);
        chk("wait_addr_hold", 32'(mem_addr_o), 32'(ea));
        chk("wait_we_hold", 32'(mem_we_o), 32'(ew));
        chk("wait_wdata_hold", mem_wdata_o, ed);
        chk("wait_busy_owner", 32'(win ? busy1_o : busy0_o), 32'd1);
        chk("wait_err", 32'(err_o), 32'd0);
      end
      k++;
    end
    mem_ack_i = 1'b0;

    chk("resp_mem_req", 32'(mem_req_o), 32'd0);
    chk("resp_err", 32'(err_o), 32'(timed));
    chk("resp_busy0", 32'(busy0_o), 32'(r0 && win));
    chk("resp_busy1", 32'(busy1_o), 32'(r1 && !win));
    if (ew == 4'b0000)
      chk("resp_rdata", win ? rdata1_o : rdata0_o, timed ? 32'd0 : ack_data);

    @(posedge clk_i); #1;
    chk("post_err", 32'(err_o), 32'd0);
    chk("post_mem_req", 32'(mem_req_o), 32'd0);
    chk("post_busy0", 32'(busy0_o), 32'(r0));
    chk("post_busy1", 32'(busy1_o), 32'(r1));
  endtask

  initial begin
    logic [3:0]  seq_expect;
    logic        g;
    logic [9:0]  cont_seq;

    rst_i = 1'b1;
    req0_i = 0; req1_i = 0; we0_i = 0; we1_i = 0; addr0_i = 0; addr1_i = 0;
    wdata0_i = 0; wdata1_i = 0; mem_rdata_i = 0; mem_ack_i = 0;
    #3;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    chk("rst_rdata0", rdata0_o, 32'd0);
    chk("rst_rdata1", rdata1_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_owner", 32'(owner_o), 32'd0);
    #9 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Single load, ack in second WAIT cycle: IDLE, WAIT, WAIT, RESP.
    do_access(1, 0, 4'b0000, 4'b0000, 30'h100, 30'h0, 32'h0, 32'h0, 1, 32'hDEADBEEF, g);
    chk("load_rdata0", rdata0_o, 32'hDEADBEEF);

    // Store from aux port; core busy stays low throughout.
    do_access(0, 1, 4'b0000, 4'b0011, 30'h0, 30'h2A5, 32'h0, 32'h0000ABCD, 2, 32'h0, g);
    chk("store_owner", 32'(g), 32'd1);

    // Contention with immediate ack.
    cont_seq = 10'b1000010000;
    for (int i = 0; i < 10; i++) begin
      do_access(1, 1, 4'b0000, 4'b0000, 30'(i), 30'(i + 100), 32'h0, 32'h0, 0,
                $urandom, g);
      chk("contention_seq", 32'(g), 32'(cont_seq[i]));
    end

    // Timeout with no ack, then ack coincident with the final timeout cycle.
    do_access(1, 0, 4'b0000, 4'b0000, 30'h55, 30'h0, 32'h0, 32'h0, 1000, 32'h0, g);
    chk("timeout_rdata0", rdata0_o, 32'd0);
    do_access(1, 0, 4'b0000, 4'b0000, 30'h56, 30'h0, 32'h0, 32'h0, TMO - 1, 32'h12345678, g);
    chk("coincident_rdata0", rdata0_o, 32'h12345678);

    // Async reset in the middle of WAIT.
    req0_i = 1; req1_i = 0; we0_i = 0; addr0_i = 30'h3C0;
    @(posedge clk_i); #1;
    chk("rstmid_mem_req_before", 32'(mem_req_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("rstmid_mem_req", 32'(mem_req_o), 32'd0);
    chk("rstmid_err", 32'(err_o), 32'd0);
    chk("rstmid_busy0", 32'(busy0_o), 32'd1);
    @(posedge clk_i); #1;
    chk("rstmid_err_held", 32'(err_o), 32'd0);
    #2 rst_i = 1'b0;
    streak_m = 0;
    @(posedge clk_i); #1;
    chk("rstmid_regrant", 32'(mem_req_o), 32'd1);
    chk("rstmid_regrant_addr", 32'(mem_addr_o), 32'h3C0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    chk("rstmid_resp_rdata0", rdata0_o, 32'hCAFEF00D);
    chk("rstmid_resp_err", 32'(err_o), 32'd0);
    @(posedge clk_i); #1;

    // Random traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      bit   r0, r1;
      int   lat;
      logic [3:0] w0, w1;
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      seq_expect = 4'($urandom);
      lat = (seq_expect == 4'hF) ? 20 : ((seq_expect == 4'hE) ? TMO - 1 : int'($urandom_range(0, 3)));
      w0 = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      w1 = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      do_access(r0, r1, w0, w1, 30'($urandom), 30'($urandom), $urandom, $urandom,
                lat, $urandom, g);
    end

    req0_i = 0; req1_i = 0;
    @(posedge clk_i); #1;
    chk("final_idle_mem_req", 32'(mem_req_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
